// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: the FSM state encoding, the default operand width, and the LO value
// written on a divide by zero (all-ones, sliced to XLEN by users).
package md_sequencer_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/md_sequencer_if.sv
// Core-side bundle between the control unit / decode stage and the Lo/Hi
// sequencer.
//   start, is_mult, is_unsigned, op_a, op_b : mult/div issue
//   rd_req, rd_hi, rd_data                  : MFHI/MFLO read port
//   hi, lo                                  : architectural HI/LO registers
//   busy, stall, done, div_zero             : status / pipeline control
// The master modport is the core; the slave modport is the sequencer.
interface md_sequencer_if
  import md_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic            is_mult;
  logic            is_unsigned;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            rd_req;
  logic            rd_hi;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            stall;
  logic            done;
  logic            div_zero;

  modport master (
    output start, is_mult, is_unsigned, op_a, op_b, rd_req, rd_hi,
    input  rd_data, hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  start, is_mult, is_unsigned, op_a, op_b, rd_req, rd_hi,
    output rd_data, hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/md_iter_core.sv
// Iteration datapath for the sequencer: a 2*XLEN accumulator, the operand
// register and the iteration down-counter.
//   load    : load acc = {0, load_lo}, operand = load_m, counter = ITER-1
//   step    : perform one shift-add (is_mult) or restoring-divide iteration
//   last    : counter has reached zero (current step is the final one)
//   acc     : multiply -> full product; divide -> {remainder, quotient}
module md_iter_core #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_mult,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   load_m,
  output logic              last,
  output logic [2*XLEN-1:0] acc
);
  localparam int CW = $clog2(ITER + 1);

  logic [XLEN-1:0]   m_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;

  always_comb begin
    // Multiply: upper half accumulates the multiplicand when the low bit of
    // the multiplier is set, then the whole accumulator shifts right.
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    // Divide: remainder shifted left with the next dividend bit; a set MSB of
    // the difference means the trial subtraction went negative (restore).
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, m_q};
    if (is_mult) begin
      acc_next = {add_sum, acc_q[XLEN-1:1]};
    end else if (rem_diff[XLEN]) begin
      acc_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, load_lo};
      m_q   <= load_m;
      cnt_q <= CW'(ITER - 1);
    end else if (step) begin
      acc_q <= acc_next;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == '0);
  assign acc  = acc_q;
endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register for the core.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : md_sequencer_if slave (issue, MFHI/MFLO read, HI/LO, status)
// Operands are captured on acceptance; sign handling is done around the
// unsigned md_iter_core datapath.
//
// state | meaning
// IDLE  | waiting for start; HI/LO readable without stall
// PREP  | take magnitudes and signs; detect divide by zero
// RUN   | ITER datapath iterations, one per cycle
// FIX   | apply result signs and write HI/LO
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = XLEN
) (
  input logic           clk,
  input logic           rst_n,
  md_sequencer_if.slave bus
);
  md_state_e state_q, state_d;

  logic [XLEN-1:0]   a_q, b_q, hi_q, lo_q;
  logic              mult_q, uns_q, sa_q, sb_q, zero_q;
  logic              busy_q, done_q, dz_q;
  logic              a_neg, b_neg, b_is_zero;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              core_load, core_step, core_last;
  logic [2*XLEN-1:0] core_acc, prod;
  logic [XLEN-1:0]   quo, rem;

  assign a_neg     = !uns_q && a_q[XLEN-1];
  assign b_neg     = !uns_q && b_q[XLEN-1];
  assign a_abs     = a_neg ? -a_q : a_q;
  assign b_abs     = b_neg ? -b_q : b_q;
  assign b_is_zero = (b_q == '0);

  assign prod = (sa_q ^ sb_q) ? -core_acc : core_acc;
  assign quo  = (sa_q ^ sb_q) ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
  assign rem  = sa_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_PREP;
      ST_PREP: begin
        if (!mult_q && b_is_zero) begin
          state_d = ST_FIX;
        end else begin
          core_load = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mult_q  <= 1'b0;
      uns_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_FIX);
      dz_q    <= (state_q == ST_FIX) && zero_q;
      if (state_q == ST_IDLE && bus.start) begin
        a_q    <= bus.op_a;
        b_q    <= bus.op_b;
        mult_q <= bus.is_mult;
        uns_q  <= bus.is_unsigned;
      end
      if (state_q == ST_PREP) begin
        sa_q   <= a_neg;
        sb_q   <= b_neg;
        zero_q <= !mult_q && b_is_zero;
      end
      if (state_q == ST_FIX) begin
        if (zero_q) begin
          hi_q <= a_q;
          lo_q <= DIV_ZERO_LO[XLEN-1:0];
        end else if (mult_q) begin
          hi_q <= prod[2*XLEN-1:XLEN];
          lo_q <= prod[XLEN-1:0];
        end else begin
          hi_q <= rem;
          lo_q <= quo;
        end
      end
    end
  end

  md_iter_core #(
    .XLEN (XLEN),
    .ITER (ITER)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (core_load),
    .step    (core_step),
    .is_mult (mult_q),
    .load_lo (mult_q ? b_abs : a_abs),
    .load_m  (mult_q ? a_abs : b_abs),
    .last    (core_last),
    .acc     (core_acc)
  );

  // A read is frozen while an operation is in flight or being accepted now,
  // so MFHI/MFLO never observe a stale HI/LO.
  assign bus.stall    = (bus.start && state_q != ST_IDLE) ||
                        (bus.rd_req && (state_q != ST_IDLE || bus.start));
  assign bus.rd_data  = bus.rd_hi ? hi_q : lo_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the driver pushes expected HI/LO and the
// expected completion edge on each acceptance; a monitor pops on every done.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_sequencer_if #(.XLEN(32)) bus();

  md_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned done_edge;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned edge_n      = 0;
  int unsigned accept_edge = 0;
  int unsigned idle_from   = 0;
  int          n_checks    = 0;
  int          n_pass      = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
  endfunction

  // Reference results straight from integer arithmetic (truncating division).
  function automatic void ref_model(input logic m, input logic u, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rh,
                                    output logic [31:0] rl, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      if (u) p = {32'h0, a} * {32'h0, b};
      else   p = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'h0) begin
      rh = a;
      rl = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (u) begin
      rl = a / b;
      rh = a % b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // Holds start until the bench's own occupancy model says the sequencer is
  // idle, checking stall every cycle, then records the expectation.
  task automatic issue(input logic m, input logic u, input logic [31:0] a, input logic [31:0] b,
                       input logic use_exp, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    exp_t e;
    logic busy_m;
    int   tries = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_mult = m; bus.is_unsigned = u; bus.op_a = a; bus.op_b = b;
    forever begin
      #1;
      busy_m = (edge_n < idle_from);
      chk("stall_issue", {63'h0, bus.stall}, {63'h0, busy_m | bus.rd_req});
      if (!busy_m) break;
      tries++;
      if (tries > 100) begin
        n_checks++;
        $display("FAIL accept_timeout: still waiting after %0d cycles", tries);
        break;
      end
      @(negedge clk);
    end
    if (use_exp) begin e.hi = ehi; e.lo = elo; e.dz = edz; end
    else ref_model(m, u, a, b, e.hi, e.lo, e.dz);
    accept_edge = edge_n + 1;
    idle_from   = accept_edge + ((!m && b == 32'h0) ? 2 : 34);
    e.done_edge = idle_from;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("busy", {63'h0, bus.busy}, {63'h0, (edge_n >= accept_edge && edge_n < idle_from)});
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: got done=1 want done=0 at t=%0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("hi", {32'h0, bus.hi}, {32'h0, e.hi});
        chk("lo", {32'h0, bus.lo}, {32'h0, e.lo});
        chk("div_zero", {63'h0, bus.div_zero}, {63'h0, e.dz});
        chk("done_edge", {32'h0, edge_n}, {32'h0, e.done_edge});
      end
    end else begin
      chk("div_zero_no_done", {63'h0, bus.div_zero}, 64'h0);
    end
  end

  initial begin
    bus.start = 1'b0; bus.is_mult = 1'b0; bus.is_unsigned = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_req = 1'b0; bus.rd_hi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'h0, bus.hi}, 64'h0);
    chk("rst_lo", {32'h0, bus.lo}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_stall", {63'h0, bus.stall}, 64'h0);
    #3 rst_n = 1'b1;

    // Directed results with hand-derived constants.
    issue(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0); idle(1);
    issue(1, 0, 32'hFFFF_FFFD, 32'h0000_0005, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0); idle(0);
    issue(0, 0, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0); idle(2);
    issue(0, 1, 32'h0000_0007, 32'h0000_0000, 1, 32'h0000_0007, 32'hFFFF_FFFF, 1); idle(1);
    issue(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 0);
    // Back-to-back: the second MULT is held while the divide runs.
    issue(1, 0, 32'h0001_2345, 32'hFFFF_FCDF, 0, '0, '0, 0);
    issue(1, 1, 32'h0000_0006, 32'h0000_0007, 1, 32'h0000_0000, 32'h0000_002A, 0);

    // MFLO held in decode right behind the MULTU 6 x 7.
    @(negedge clk);
    bus.start = 1'b0; bus.rd_req = 1'b1; bus.rd_hi = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("stall_read", {63'h0, bus.stall}, {63'h0, edge_n < idle_from});
      if (edge_n >= idle_from) begin
        chk("rd_data_lo", {32'h0, bus.rd_data}, 64'h2A);
        bus.rd_hi = 1'b1;
        #1 chk("rd_data_hi", {32'h0, bus.rd_data}, 64'h0);
        break;
      end
      @(negedge clk);
    end
    bus.rd_req = 1'b0;

    // Reset in the 10th cycle of a DIV.
    issue(0, 0, 32'hFFFF_FF9C, 32'h0000_0007, 0, '0, '0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    while (edge_n < accept_edge + 9) @(negedge clk);
    #3 rst_n = 1'b0;
    sb_q.delete();
    accept_edge = edge_n;
    idle_from   = edge_n;
    #1;
    chk("mid_rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("mid_rst_hi", {32'h0, bus.hi}, 64'h0);
    chk("mid_rst_lo", {32'h0, bus.lo}, 64'h0);
    chk("mid_rst_done", {63'h0, bus.done}, 64'h0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    issue(0, 0, 32'hFFFF_FF9C, 32'h0000_0007, 0, '0, '0, 0);

    // Randomized operations, sometimes back-to-back.
    for (int n = 0; n < 24; n++) begin
      logic m, u;
      logic [31:0] a, b;
      m = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
      issue(m, u, a, b, 0, '0, '0, 0);
    end

    idle(0);
    while (edge_n < idle_from + 1) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multi-cycle sequencer for the Multiplication/Division Processor and the Lo/Hi Register in the MIPS core. It accepts MULT/MULTU/DIV/DIVU issued by the control unit and runs a 32-iteration shift-add / restoring-divide loop. When the loop finishes it commits HI/LO. While an operation is in flight it stalls any new mult/div issue and any MFHI/MFLO read, so the core's timing stays independent of the operation.

Parameters:
XLEN, 32, operand width; HI/LO are XLEN each, product is 2*XLEN.
ITER, XLEN, iteration count of the RUN state.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  mult/div issue (lhr_wen from control unit), level while instruction held
is_mult  in  1  1 = multiply, 0 = divide
is_unsigned  in  1  1 = MULTU/DIVU
op_a  in  XLEN  rs value (multiplicand / dividend)
op_b  in  XLEN  rt value (multiplier / divisor)
rd_req  in  1  MFHI/MFLO in decode (lhr_ren)
rd_hi  in  1  1 = MFHI, 0 = MFLO (lhr_is_hi)
rd_data  out  XLEN  combinational: rd_hi ? hi : lo
hi  out  XLEN  HI register
lo  out  XLEN  LO register
busy  out  1  registered, high in any state other than IDLE
stall  out  1  combinational freeze-PC/instruction request
done  out  1  one-cycle pulse coincident with the first cycle HI/LO hold the new value
div_zero  out  1  one-cycle pulse with done when a divide had op_b == 0

Behaviour:
- Clock and reset: clk; reset asynchronous, active-low (rst_n). Reset values: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, all internal registers 0.
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - start = 1 is accepted: latch op_a, op_b, is_mult, is_unsigned → PREP.
  - The issuing instruction is not stalled in this cycle; it retires.
- PREP, 1 cycle:
  - Signed operations: take absolute values and record sa = op_a[XLEN-1], sb = op_b[XLEN-1].
  - Unsigned operations: sa = sb = 0.
  - Divide with op_b == 0: go to FIX with the zero flag set. Otherwise load the iteration counter with ITER-1 → RUN.
- RUN, exactly ITER cycles, one iteration per cycle:
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter reaches 0 → FIX.
- FIX, 1 cycle; HI/LO are written at the end of FIX:
  - Multiply: negate the 2*XLEN product if sa^sb. hi = upper half, lo = lower half.
  - Divide: lo = quotient, negated if sa^sb; hi = remainder, negated if sa.
  - Divide-by-zero: hi = op_a (raw latched value), lo = all-ones, regardless of signedness.
  - Then → IDLE.
- done and div_zero: registered, high in the first IDLE cycle after FIX.
- Latency: start sampled at edge 0. New HI/LO are visible from cycle ITER+3 (35 for XLEN = 32). Divide-by-zero results are visible from cycle 3.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0. No trap.
- stall = (start & state != IDLE) | (rd_req & (state != IDLE | start)).
  - A read in the same cycle as an accepted start stalls.
  - A back-to-back mult/div waits until IDLE, then is accepted.
- HI/LO hold their values outside FIX. rd_data always reflects the current registers.
- Reset mid-operation: immediate return to IDLE. hi/lo clear to 0. No done pulse is produced.
- start with X-free operands only. Operand changes after acceptance are ignored.

Decomposition:
- Shared package: state encoding (IDLE, PREP, RUN, FIX), XLEN default, and the divide-by-zero LO constant (all-ones).
- Natural sub-module: md_iter_core. It holds the accumulator/remainder register, the shift-add/subtract step and the counter, driven by load/step signals from the md_sequencer FSM.
- Sign pre- and post-processing stays in md_sequencer.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. done pulses 35 cycles after start; busy is high for cycles 1–34.
- MULT −3 × 5 (0xFFFFFFFD, 0x00000005) → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 7 / 0 → hi = 0x00000007, lo = 0xFFFFFFFF. done and div_zero pulse together at cycle 3. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MULTU 6 × 7 followed by MFLO held in decode → stall high from cycle 1 until done. rd_data = 0x0000002A in the first unstalled cycle.
- Second MULT held asserted while busy → stall high, not accepted until IDLE, then accepted and completes with its own result.
- Assert rst_n = 0 at cycle 10 of a DIV → busy = 0, hi = lo = 0 immediately, no done pulse. Next start after release completes normally.
